// File: rtl/bin_to_gray.sv
// -----------------------------------------------------------------------------
// bin_to_gray
//
// Binary-to-Gray converter with two views of the same conversion:
//   * a purely combinational output that follows data_in_i with no latency,
//   * a registered copy captured on valid_i beats, with a one-cycle latency.
//
// Ports
//   clk_i       in   1          rising-edge clock for the registered path
//   arst_i      in   1          asynchronous, active-high reset
//   data_in_i   in   DataWidth  unsigned binary value to convert
//   data_out_o  out  DataWidth  combinational Gray code of data_in_i
//   valid_i     in   1          qualifies data_in_i for the registered path
//   data_q_o    out  DataWidth  registered Gray code
//   valid_o     out  1          data_q_o was loaded on the most recent edge
//
// Handshake: valid_i/valid_o form a push-only stream. There is no ready;
// every cycle with valid_i = 1 is captured on the next rising clk_i edge and
// appears on data_q_o one cycle later with valid_o = 1. A cycle with
// valid_i = 0 leaves data_q_o unchanged and drives valid_o low.
// -----------------------------------------------------------------------------
module bin_to_gray #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [DataWidth-1:0] data_in_i,
  output logic [DataWidth-1:0] data_out_o,
  input  logic                 valid_i,
  output logic [DataWidth-1:0] data_q_o,
  output logic                 valid_o
);

  logic [DataWidth-1:0] gray;
  logic [DataWidth-1:0] data_q_d;
  logic [DataWidth-1:0] data_q_q;
  logic                 valid_d;
  logic                 valid_q;

  // Each Gray bit is the XOR of a binary bit with its upper neighbour; the
  // logical shift feeds a zero into the MSB, so the MSB passes straight
  // through. With DataWidth = 1 the shift yields zero and gray == data_in_i.
  assign gray       = data_in_i ^ (data_in_i >> 1);
  assign data_out_o = gray;

  always_comb begin
    data_q_d = data_q_q;
    valid_d  = valid_i;
    if (valid_i) begin
      data_q_d = gray;
    end
  end

  // Reset wins over any edge or beat that coincides with it.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_q_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      data_q_q <= data_q_d;
      valid_q  <= valid_d;
    end
  end

  assign data_q_o = data_q_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_bin_to_gray.sv
module tb_bin_to_gray;

  localparam int W = 11;
  localparam int N = 1 << W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic arst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (DataWidth = 11) ----------------
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         valid_in;
  logic [W-1:0] data_q;
  logic         valid_out;

  bin_to_gray #(.DataWidth(W)) u_dut (
    .clk_i      (clk),
    .arst_i     (arst),
    .data_in_i  (data_in),
    .data_out_o (data_out),
    .valid_i    (valid_in),
    .data_q_o   (data_q),
    .valid_o    (valid_out)
  );

  // ---------------- DUT (DataWidth = 1) ----------------
  logic d1_in;
  logic d1_out;
  logic d1_valid_in;
  logic d1_q;
  logic d1_valid_out;

  bin_to_gray #(.DataWidth(1)) u_dut_w1 (
    .clk_i      (clk),
    .arst_i     (arst),
    .data_in_i  (d1_in),
    .data_out_o (d1_out),
    .valid_i    (d1_valid_in),
    .data_q_o   (d1_q),
    .valid_o    (d1_valid_out)
  );

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  logic [W-1:0] exp_q[$];

  // Reference: reflected binary code, g = n xor floor(n/2).
  function automatic logic [W-1:0] gray_model(int unsigned n);
    int unsigned v;
    v = n % N;
    return W'(v ^ (v / 2));
  endfunction

  // Inverse: binary bit i is the parity of the Gray bits at or above i.
  function automatic int unsigned gray_decode(logic [W-1:0] g);
    int unsigned b;
    logic [W-1:0] s;
    b = 0;
    for (int i = 0; i < W; i++) begin
      s = g >> i;
      if (($countones(s) % 2) == 1) b = b + (1 << i);
    end
    return b;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst = 1'b1;
    valid_in = 1'b0;
    data_in = '0;
    d1_in = 1'b0;
    d1_valid_in = 1'b0;
    #1;
    checks++;
    if (data_q !== '0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data_q=%h valid=%b required data_q=000 valid=0", data_q, valid_out);
    end
    tick();
    tick();
    #2 arst = 1'b0;
    tick();
    checks++;
    if (data_q !== '0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: data_q=%h valid=%b required data_q=000 valid=0", data_q, valid_out);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ins  [7];
    logic [W-1:0] outs [7];
    ins  = '{11'h000, 11'h001, 11'h002, 11'h003, 11'h400, 11'h7FF, 11'h555};
    outs = '{11'h000, 11'h001, 11'h003, 11'h002, 11'h600, 11'h400, 11'h7FF};
    for (int i = 0; i < 7; i++) begin
      data_in = ins[i];
      #1;
      checks++;
      if (data_out !== outs[i]) begin
        errors++;
        $display("FAIL directed_%0d: in=%h out=%h required=%h", i, ins[i], data_out, outs[i]);
      end
    end
  endtask

  task automatic test_sweep();
    bit seen [N];
    int pass_cnt;
    int total;
    int distinct;
    logic [W-1:0] r;
    pass_cnt = 0;
    total = 0;
    distinct = 0;
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    for (int n = 0; n < N; n++) begin
      data_in = W'(n);
      #1;
      total++;
      checks++;
      if (data_out !== gray_model(n) || gray_decode(data_out) != n) begin
        errors++;
        $display("FAIL sweep: in=%h out=%h required=%h", W'(n), data_out, gray_model(n));
      end else begin
        pass_cnt++;
      end
      if (!$isunknown(data_out) && !seen[data_out]) begin
        seen[data_out] = 1'b1;
        distinct++;
      end
    end
    checks++;
    if (distinct != N) begin
      errors++;
      $display("FAIL bijective: distinct=%0d required=%0d", distinct, N);
    end
    for (int k = 0; k < N; k++) begin
      r = W'($urandom_range(N - 1, 0));
      data_in = r;
      #1;
      total++;
      checks++;
      if (data_out !== gray_model(r)) begin
        errors++;
        $display("FAIL sweep_rand: in=%h out=%h required=%h", r, data_out, gray_model(r));
      end else begin
        pass_cnt++;
      end
    end
    $display("combinational sweep: %0d / %0d passed", pass_cnt, total);
  endtask

  task automatic test_registered();
    data_in = 11'h400;
    valid_in = 1'b1;
    tick();
    checks++;
    if (data_q !== 11'h600 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL reg_load: data_q=%h valid=%b required data_q=600 valid=1", data_q, valid_out);
    end
    data_in = 11'h123;
    valid_in = 1'b0;
    tick();
    checks++;
    if (data_q !== 11'h600 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reg_hold: data_q=%h valid=%b required data_q=600 valid=0", data_q, valid_out);
    end
  endtask

  task automatic test_async_reset();
    data_in = 11'h2A5;
    #2 arst = 1'b1;
    #1;
    checks++;
    if (data_q !== '0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data_q=%h valid=%b required data_q=000 valid=0", data_q, valid_out);
    end
    checks++;
    if (data_out !== gray_model(11'h2A5)) begin
      errors++;
      $display("FAIL comb_in_reset: out=%h required=%h", data_out, gray_model(11'h2A5));
    end
    // Beats offered during reset must be ignored.
    valid_in = 1'b1;
    tick();
    checks++;
    if (data_q !== '0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_clk: data_q=%h valid=%b required data_q=000 valid=0", data_q, valid_out);
    end
    valid_in = 1'b0;
    #2 arst = 1'b0;
    tick();
    checks++;
    if (data_q !== '0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: data_q=%h valid=%b required data_q=000 valid=0", data_q, valid_out);
    end
    // First valid edge after release captures.
    data_in = 11'h0F0;
    valid_in = 1'b1;
    tick();
    checks++;
    if (data_q !== gray_model(11'h0F0) || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL first_capture: data_q=%h valid=%b required data_q=%h valid=1", data_q, valid_out, gray_model(11'h0F0));
    end
  endtask

  task automatic test_reset_discard();
    // Beat presented, then reset held across the edge that would capture it.
    data_in = 11'h3C3;
    valid_in = 1'b1;
    #6 arst = 1'b1;
    @(posedge clk);
    #2 arst = 1'b0;
    valid_in = 1'b0;
    #1;
    checks++;
    if (data_q !== '0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: data_q=%h valid=%b required data_q=000 valid=0", data_q, valid_out);
    end
    tick();
  endtask

  task automatic test_counter_walk();
    logic [W-1:0] prev;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    bit have_prev;
    have_prev = 1'b0;
    prev = '0;
    for (int n = 0; n <= N; n++) begin
      data_in = W'(n % N);
      valid_in = 1'b1;
      exp_q.push_back(gray_model(n));
      tick();
      got = data_q;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL walk_value: n=%0d data_q=%h valid=%b required=%h valid=1", n, got, valid_out, exp);
      end
      if (have_prev) begin
        checks++;
        if ($countones(got ^ prev) != 1) begin
          errors++;
          $display("FAIL walk_one_bit: n=%0d prev=%h cur=%h bits_changed=%0d required=1", n, prev, got, $countones(got ^ prev));
        end
      end
      prev = got;
      have_prev = 1'b1;
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back_random();
    logic [W-1:0] r;
    logic [W-1:0] held;
    held = data_q;
    for (int k = 0; k < 200; k++) begin
      r = W'($urandom);
      data_in = r;
      valid_in = 1'($urandom_range(1, 0));
      if (valid_in) held = gray_model(r);
      exp_q.push_back(held);
      tick();
      checks++;
      if (data_q !== exp_q.pop_front()) begin
        errors++;
        $display("FAIL rand_reg: k=%0d data_q=%h required=%h", k, data_q, held);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_width1();
    for (int v = 0; v < 2; v++) begin
      d1_in = 1'(v);
      #1;
      checks++;
      if (d1_out !== 1'(v)) begin
        errors++;
        $display("FAIL width1_%0d: out=%b required=%b", v, d1_out, 1'(v));
      end
    end
    d1_in = 1'b1;
    d1_valid_in = 1'b1;
    tick();
    checks++;
    if (d1_q !== 1'b1 || d1_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL width1_reg: q=%b valid=%b required q=1 valid=1", d1_q, d1_valid_out);
    end
    d1_valid_in = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_sweep();
    tick();
    test_registered();
    test_async_reset();
    test_reset_discard();
    test_counter_walk();
    test_back_to_back_random();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_gray.md
BIN_TO_GRAY -- requirements
Module: bin_to_gray

Interface
REQ-001 The module SHALL have parameter DataWidth, default 8, giving the bit width of the binary input and the Gray output; legal range 1..64.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all registered logic samples on its rising edge.
REQ-003 The module SHALL have port arst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port data_in_i, input, DataWidth bits: unsigned binary value to convert.
REQ-005 The module SHALL have port data_out_o, output, DataWidth bits: combinational Gray code of data_in_i.
REQ-006 The module SHALL have port valid_i, input, 1 bit: qualifies data_in_i for the registered path.
REQ-007 The module SHALL have port data_q_o, output, DataWidth bits: registered Gray code.
REQ-008 The module SHALL have port valid_o, output, 1 bit: data_q_o holds a freshly captured value.

Function
REQ-009 data_out_o[DataWidth-1] SHALL equal data_in_i[DataWidth-1].
REQ-010 For i = 0..DataWidth-2, data_out_o[i] SHALL equal data_in_i[i] XOR data_in_i[i+1], equivalent to data_in_i XOR (data_in_i >> 1), logical shift.
REQ-011 data_out_o SHALL be purely combinational: zero cycles of latency, no dependence on clk_i, arst_i or valid_i, and settled within the same delta-time window as any data_in_i change.
REQ-012 The conversion SHALL be bijective over all 2^DataWidth inputs, with no X generation for fully-known inputs.
REQ-013 With DataWidth = 1, data_out_o SHALL equal data_in_i.
REQ-014 On a rising clk_i edge with valid_i = 1, data_q_o SHALL load the current data_out_o value and valid_o SHALL become 1.
REQ-015 On a rising clk_i edge with valid_i = 0, data_q_o SHALL hold its value and valid_o SHALL become 0.
REQ-016 The registered path SHALL have a latency of exactly 1 cycle; there is no backpressure and every valid_i beat is captured.
REQ-017 Successive registered outputs for inputs n and n+1 (mod 2^DataWidth) SHALL differ in exactly one bit, including the wrap from all-ones to 0.

Reset
REQ-018 Asserting arst_i SHALL immediately, without waiting for clk_i, force data_q_o = 0 and valid_o = 0.
REQ-019 While arst_i = 1, the registers SHALL ignore clk_i and valid_i.
REQ-020 data_out_o SHALL continue to track data_in_i during reset.
REQ-021 After arst_i deasserts, the first capture SHALL occur on the first rising clk_i edge with valid_i = 1.
REQ-022 Asserting arst_i in the same cycle as a valid_i beat SHALL discard that beat.

Verification (DataWidth = 11)
REQ-023 Combinational sweep: apply all 2048 inputs, or at least 2048 random values, waiting 1 time unit after each -> data_out_o equals the REQ-009/REQ-010 model for every value, reported as a pass count out of total.
REQ-024 Directed points: inputs 0x000, 0x001, 0x002, 0x003 -> outputs 0x000, 0x001, 0x003, 0x002; inputs 0x400, 0x7FF, 0x555 -> outputs 0x600, 0x400, 0x7FF.
REQ-025 Registered path: drive valid_i = 1 with data_in_i = 0x400 at edge N -> data_q_o = 0x600 and valid_o = 1 after edge N; drive valid_i = 0 at edge N+1 -> data_q_o stays 0x600 and valid_o = 0.
REQ-026 Async reset: pulse arst_i between clock edges while data_q_o = 0x600 -> data_q_o = 0 and valid_o = 0 with no clock edge; data_out_o unaffected throughout.
REQ-027 Counter walk: feed 0..2047 then 0 with valid_i = 1 every cycle -> consecutive data_q_o values differ in exactly one bit, including at the 0x7FF -> 0x000 wrap.
REQ-028 Width corner: elaborate with DataWidth = 1 and apply inputs 0 and 1 -> data_out_o = 0 and 1 respectively.
